cpri_prb_pattern_gen: RTL and testbench

Parametrised CPRI PRB test-pattern generator. Plays back a per-lane sample stream for a programmable frame of symbols, with a configurable active-symbol mask, a chip-aligned SOP strobe, and start/stop/single-shot control. It sits ahead of the PUSCH dimension-reduction datapath as a stimulus source and replaces fixed 8-lane, free-running pattern playback.

---
 rtl/cpri_prb_pattern_gen.sv | 184 ++++++++++++++++++
 tb/tb_cpri_prb_pattern_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/cpri_prb_pattern_gen.sv
// CPRI PRB test-pattern generator: masked symbol playback, chip-aligned SOP, start/stop/single-shot control.
// Optional CPRI_PRB_GEN_EXT_MEM_EN sources lane data from an external one-cycle-latency memory.
module cpri_prb_pattern_gen #(
    parameter int                       NUM_LANES     = 8,
    parameter int                       DAT_DW        = 64,
    parameter int                       ADDR_W        = 16,
    parameter int                       SYM_LEN       = 44352,
    parameter int                       SYM_PER_FRAME = 5,
    parameter logic [SYM_PER_FRAME-1:0] ACTIVE_MASK   = 5'b00001,
    parameter int                       CHIP_LEN      = 96,
    parameter int                       SOP_OFFSET    = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          stop_i,
    input  logic                          mode_i,
    output logic                          busy_o,
    output logic                          sop_o,
    output logic                          valid_o,
    output logic [7:0]                    sym_idx_o,
    output logic [NUM_LANES*DAT_DW-1:0]   dat_o
`ifdef CPRI_PRB_GEN_EXT_MEM_EN
    ,
    output logic                          rd_en_o,
    output logic [ADDR_W-1:0]             rd_addr_o,
    input  logic [NUM_LANES*DAT_DW-1:0]   rd_data_i
`endif
);

    localparam int             DW       = NUM_LANES * DAT_DW;
    localparam int             CHIP_W   = (CHIP_LEN > 1) ? $clog2(CHIP_LEN) : 1;
    localparam logic [255:0]   MASK_EXT = 256'(ACTIVE_MASK);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q;
    state_t              state_d;
    logic                start_acc;
    logic                mode_q;
    logic                stop_q;
    logic                drain_cnt;
    logic [ADDR_W-1:0]   samp_cnt;
    logic [7:0]          sym_cnt;
    logic [CHIP_W-1:0]   chip_cnt;
    logic                run;
    logic                samp_last;
    logic                sym_last;
    logic                frame_end;

    assign run       = (state_q == RUN);
    assign samp_last = (samp_cnt == ADDR_W'(SYM_LEN - 1));
    assign sym_last  = (sym_cnt == 8'(SYM_PER_FRAME - 1));
    assign frame_end = run && samp_last && sym_last;

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d   = RUN;
                    start_acc = 1'b1;
                end
            end
            RUN: begin
                if (frame_end && (mode_q || stop_q || stop_i)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            busy_o    <= 1'b0;
            drain_cnt <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_o    <= (state_d != IDLE);
            drain_cnt <= (state_q == DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    // Chip counter free-runs across symbol boundaries; only start realigns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            samp_cnt <= '0;
            sym_cnt  <= '0;
            chip_cnt <= '0;
            mode_q   <= 1'b0;
            stop_q   <= 1'b0;
        end else if (start_acc) begin
            samp_cnt <= '0;
            sym_cnt  <= '0;
            chip_cnt <= '0;
            mode_q   <= mode_i;
            stop_q   <= 1'b0;
        end else if (run) begin
            if (stop_i) begin
                stop_q <= 1'b1;
            end
            chip_cnt <= (chip_cnt == CHIP_W'(CHIP_LEN - 1)) ? '0 : chip_cnt + CHIP_W'(1);
            if (samp_last) begin
                samp_cnt <= '0;
                sym_cnt  <= sym_last ? 8'd0 : sym_cnt + 8'd1;
            end else begin
                samp_cnt <= samp_cnt + ADDR_W'(1);
            end
        end
    end

    // Stage 0: decode counters into a beat descriptor.
    logic              s0_act;
    logic              s0_hit;
    logic [7:0]        s0_sym;
    logic [ADDR_W-1:0] s0_addr;

    assign s0_act  = run && MASK_EXT[sym_cnt];
    assign s0_hit  = run && (chip_cnt == CHIP_W'(SOP_OFFSET));
    assign s0_sym  = run ? sym_cnt : 8'd0;
    assign s0_addr = s0_act ? samp_cnt : '0;

    // Stage 1: registered descriptor, doubling as the external memory address register.
    logic              s1_act;
    logic              s1_hit;
    logic [7:0]        s1_sym;
    logic [ADDR_W-1:0] s1_addr;
    logic [DW-1:0]     src;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_act  <= 1'b0;
            s1_hit  <= 1'b0;
            s1_sym  <= '0;
            s1_addr <= '0;
        end else begin
            s1_act  <= s0_act;
            s1_hit  <= s0_hit;
            s1_sym  <= s0_sym;
            s1_addr <= s0_addr;
        end
    end

`ifdef CPRI_PRB_GEN_EXT_MEM_EN
    assign rd_en_o   = s1_act;
    assign rd_addr_o = s1_addr;
    assign src       = rd_data_i;
`else
    always_comb begin
        src = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            src[l*DAT_DW +: ADDR_W]          = s1_addr;
            src[l*DAT_DW + ADDR_W +: 8]      = s1_sym;
            src[l*DAT_DW + ADDR_W + 8 +: 8]  = 8'(l);
        end
    end
`endif

    // Stage 2: output register; inactive beats are forced to zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sop_o     <= 1'b0;
            valid_o   <= 1'b0;
            sym_idx_o <= '0;
            dat_o     <= '0;
        end else begin
            sop_o     <= s1_hit;
            valid_o   <= s1_act;
            sym_idx_o <= s1_sym;
            dat_o     <= s1_act ? src : '0;
        end
    end

endmodule

// File: tb/tb_cpri_prb_pattern_gen.sv
// Scoreboard bench for cpri_prb_pattern_gen: directed runs push expected beats, a negedge monitor checks them.
// Build with CPRI_PRB_GEN_EXT_MEM_EN to exercise the external-memory variant.
`timescale 1ns/1ps
module tb_cpri_prb_pattern_gen;

    localparam int         NUM_LANES  = 2;
    localparam int         DAT_DW     = 32;
    localparam int         ADDR_W     = 16;
    localparam int         SYM_LEN    = 8;
    localparam int         SPF        = 3;
    localparam logic [2:0] MASK       = 3'b101;
    localparam int         CHIP_LEN   = 4;
    localparam int         SOP_OFFSET = 1;
    localparam int         W          = NUM_LANES * DAT_DW;
    localparam int         FRAME      = SYM_LEN * SPF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          mode_i = 1'b0;
    logic          busy_o;
    logic          sop_o;
    logic          valid_o;
    logic [7:0]    sym_idx_o;
    logic [W-1:0]  dat_o;
`ifdef CPRI_PRB_GEN_EXT_MEM_EN
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [W-1:0]      rd_data_i;
    // Synchronous memory whose address register is the DUT's rd_addr_o: data follows one cycle after issue.
    assign rd_data_i = ~W'(rd_addr_o);
`endif

    cpri_prb_pattern_gen #(
        .NUM_LANES(NUM_LANES), .DAT_DW(DAT_DW), .ADDR_W(ADDR_W), .SYM_LEN(SYM_LEN),
        .SYM_PER_FRAME(SPF), .ACTIVE_MASK(MASK), .CHIP_LEN(CHIP_LEN), .SOP_OFFSET(SOP_OFFSET)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i), .mode_i(mode_i),
        .busy_o(busy_o), .sop_o(sop_o), .valid_o(valid_o), .sym_idx_o(sym_idx_o), .dat_o(dat_o)
`ifdef CPRI_PRB_GEN_EXT_MEM_EN
        , .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                cyc;
        logic [7:0]        sym;
        logic [ADDR_W-1:0] addr;
        logic [W-1:0]      dat;
    } beat_t;

    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    int    t_start = -1000;
    int    run_len = 0;
    int    kill_cyc = 32'h3fff_ffff;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    function automatic logic [W-1:0] model_dat(input logic [7:0] sym, input logic [ADDR_W-1:0] addr);
        logic [W-1:0] d;
        d = '0;
`ifdef CPRI_PRB_GEN_EXT_MEM_EN
        d = ~W'(addr);
`else
        for (int l = 0; l < NUM_LANES; l++) begin
            d[l*DAT_DW +: DAT_DW] = DAT_DW'({8'(l), sym, addr});
        end
`endif
        return d;
    endfunction

    // Expected beats: counters start in cycle T+1, outputs appear two cycles later.
    task automatic push_frames(input int t, input int frames);
        beat_t b;
        for (int f = 0; f < frames; f++) begin
            for (int s = 0; s < SPF; s++) begin
                if (MASK[s]) begin
                    for (int a = 0; a < SYM_LEN; a++) begin
                        b.cyc  = t + 3 + f * FRAME + s * SYM_LEN + a;
                        b.sym  = 8'(s);
                        b.addr = ADDR_W'(a);
                        b.dat  = model_dat(8'(s), ADDR_W'(a));
                        exp_q.push_back(b);
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin : monitor
        int    k;
        logic  exp_sop;
        logic  exp_busy;
        beat_t b;
        k        = cyc - t_start - 3;
        exp_sop  = (cyc < kill_cyc) && (k >= 0) && (k < run_len) && ((k % CHIP_LEN) == SOP_OFFSET);
        exp_busy = (cyc < kill_cyc) && (run_len > 0) && (cyc >= t_start + 1) && (cyc <= t_start + run_len + 2);
        check("sop", W'(sop_o), W'(exp_sop));
        check("busy", W'(busy_o), W'(exp_busy));
        if (valid_o) begin
            if (exp_q.size() == 0) begin
                check("beat_unexpected", W'(valid_o), '0);
            end else begin
                b = exp_q.pop_front();
                check("beat_cycle", W'(cyc), W'(b.cyc));
                check("beat_sym", W'(sym_idx_o), W'(b.sym));
                check("beat_dat", dat_o, b.dat);
            end
        end else begin
            check("idle_dat", dat_o, '0);
        end
`ifdef CPRI_PRB_GEN_EXT_MEM_EN
        if (rd_en_o) begin
            if (exp_q.size() == 0) begin
                check("rd_en_unexpected", W'(rd_en_o), '0);
            end else begin
                check("rd_addr", W'(rd_addr_o), W'(exp_q[0].addr));
                check("rd_lead", W'(exp_q[0].cyc), W'(cyc + 1));
            end
        end
`endif
    end

    task automatic do_start(input logic mode, input logic stop, input int len, input int frames);
        @(negedge clk);
        t_start  = cyc;
        run_len  = len;
        kill_cyc = 32'h3fff_ffff;
        push_frames(cyc, frames);
        start_i = 1'b1;
        stop_i  = stop;
        mode_i  = mode;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
    endtask

    // Single-shot run; a start pulse mid-run with mode 0 must be ignored.
    task automatic single_shot();
        do_start(1'b1, 1'b0, FRAME, 1);
        repeat (4) @(negedge clk);
        check("lane1_beat_T5", W'(dat_o[2*DAT_DW-1:DAT_DW]), W'(model_dat(8'd0, 16'd2) >> DAT_DW));
`ifndef CPRI_PRB_GEN_EXT_MEM_EN
        check("lane1_const_T5", W'(dat_o[2*DAT_DW-1:DAT_DW]), W'(32'h0100_0002));
`endif
        repeat (5) @(negedge clk);
        start_i = 1'b1;
        mode_i  = 1'b0;
        @(negedge clk);
        start_i = 1'b0;
        repeat (22) @(negedge clk);
        check("queue_drained", W'(exp_q.size()), '0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, W'(busy_o), '0);
        check({tag, "_sop"}, W'(sop_o), '0);
        check({tag, "_valid"}, W'(valid_o), '0);
        check({tag, "_sym"}, W'(sym_idx_o), '0);
        check({tag, "_dat"}, dat_o, '0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        single_shot();

        // Continuous mode, stop in frame 1 symbol 1: frame 1 completes, then drain.
        do_start(1'b0, 1'b0, 2 * FRAME, 2);
        repeat (34) @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        repeat (22) @(negedge clk);
        check("queue_drained_cont", W'(exp_q.size()), '0);

        // Start and stop together in IDLE: start wins, full single frame.
        do_start(1'b1, 1'b1, FRAME, 1);
        repeat (32) @(negedge clk);
        check("queue_drained_startstop", W'(exp_q.size()), '0);

        // Asynchronous reset mid symbol 2.
        do_start(1'b1, 1'b0, FRAME, 1);
        repeat (20) @(negedge clk);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        kill_cyc = cyc;
        exp_q.delete();
        #1;
        check_all_zero("async_rst");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        single_shot();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
